// File: rtl/breakout_pkg.sv
// Shared breakout playfield constants and the ball state encoding.
package breakout_pkg;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVE   = 2'd1,
        FROZEN = 2'd2
    } ball_state_t;

    localparam int unsigned X_MAX    = 639;
    localparam int unsigned Y_MAX    = 479;
    localparam int unsigned BALL_R   = 3;
    localparam int unsigned STEP     = 1;
    localparam int unsigned PADDLE_Y = 440;
    localparam int unsigned PADDLE_W = 80;
    localparam int unsigned X_START  = 320;
    localparam int unsigned Y_START  = 400;

    localparam int unsigned POS_W = 11;
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;

    // Limits on the ball centre so the whole ball stays on screen.
    localparam int unsigned XL = BALL_R;
    localparam int unsigned XR = X_MAX - BALL_R;
    localparam int unsigned YT = BALL_R;
    localparam int unsigned YB = Y_MAX - BALL_R;
    localparam int unsigned PT = PADDLE_Y - BALL_R;

endpackage

// File: rtl/ball_motion_axis_step.sv
// One axis of ball motion: wall reflection at lo/hi, forced or requested flips, one step.
module axis_step
    import breakout_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic             dir,
    input  logic [POS_W-1:0] lo,
    input  logic [POS_W-1:0] hi,
    input  logic             flip_req,
    input  logic             force_reflect,
    output logic [POS_W-1:0] next_pos,
    output logic             next_dir,
    output logic             at_limit
);

    logic w_hit_hi;
    logic w_hit_lo;
    logic w_turn;

    assign w_hit_hi = dir && ((pos + POS_W'(STEP)) > hi);
    assign w_hit_lo = !dir && (pos < (lo + POS_W'(STEP)));
    assign at_limit = w_hit_hi | w_hit_lo;

    // Any reason to turn flips once; a wall and a brick together never double-flip.
    assign w_turn   = at_limit | force_reflect | flip_req;
    assign next_dir = w_turn ? ~dir : dir;
    assign next_pos = next_dir ? (pos + POS_W'(STEP)) : (pos - POS_W'(STEP));

endmodule

// File: rtl/ball_motion.sv
// Breakout ball position generator: serve, bounce off walls/paddle/bricks, freeze on death.
module ball_motion
    import breakout_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        launch,
    input  logic [9:0]  paddle_x,
    input  logic        brick_hit_x,
    input  logic        brick_hit_y,
    input  logic        gameOver,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic        moving
);

    ball_state_t      r_state;
    ball_state_t      w_state_nxt;
    logic [X_W-1:0]   r_x;
    logic [X_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]   r_y;
    logic [Y_W-1:0]   w_y_nxt;
    logic             r_dx;
    logic             w_dx_nxt;
    logic             r_dy;
    logic             w_dy_nxt;
    logic             r_moving;

    logic [POS_W-1:0] w_x11;
    logic [POS_W-1:0] w_y11;
    logic [POS_W-1:0] w_px11;
    logic [POS_W-1:0] w_x_step;
    logic [POS_W-1:0] w_y_step;
    logic             w_dx_step;
    logic             w_dy_step;
    logic             w_x_lim;
    logic             w_y_lim;
    logic             w_paddle_hit;
    logic             w_flip_x;
    logic             w_flip_y;
    logic             w_floor;

    assign w_x11  = POS_W'(r_x);
    assign w_y11  = POS_W'(r_y);
    assign w_px11 = POS_W'(paddle_x);

    // Paddle catch: this step would carry a falling ball past the paddle top inside its span.
    assign w_paddle_hit = r_dy
                       && (w_y11 <= POS_W'(PT))
                       && ((w_y11 + POS_W'(STEP)) > POS_W'(PT))
                       && (w_x11 >= w_px11)
                       && (w_x11 <= (w_px11 + POS_W'(PADDLE_W - 1)));

    // Brick pulses lose to any wall/paddle reflection on the same axis.
    assign w_flip_x = brick_hit_x & ~w_x_lim;
    assign w_flip_y = brick_hit_y & ~w_y_lim & ~w_paddle_hit;
    assign w_floor  = r_dy & w_y_lim;

    axis_step u_axis_x (
        .pos           (w_x11),
        .dir           (r_dx),
        .lo            (POS_W'(XL)),
        .hi            (POS_W'(XR)),
        .flip_req      (w_flip_x),
        .force_reflect (1'b0),
        .next_pos      (w_x_step),
        .next_dir      (w_dx_step),
        .at_limit      (w_x_lim)
    );

    axis_step u_axis_y (
        .pos           (w_y11),
        .dir           (r_dy),
        .lo            (POS_W'(YT)),
        .hi            (POS_W'(YB)),
        .flip_req      (w_flip_y),
        .force_reflect (w_paddle_hit),
        .next_pos      (w_y_step),
        .next_dir      (w_dy_step),
        .at_limit      (w_y_lim)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SERVE;
            r_x      <= X_W'(X_START);
            r_y      <= Y_W'(Y_START);
            r_dx     <= 1'b1;
            r_dy     <= 1'b0;
            r_moving <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_dx     <= w_dx_nxt;
            r_dy     <= w_dy_nxt;
            r_moving <= (w_state_nxt == MOVE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        case (r_state)
            SERVE: begin
                w_x_nxt  = X_W'(X_START);
                w_y_nxt  = Y_W'(Y_START);
                w_dx_nxt = 1'b1;
                w_dy_nxt = 1'b0;
                if (launch) begin
                    w_state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (gameOver) begin
                    w_state_nxt = FROZEN;
                end else begin
                    w_x_nxt  = X_W'(w_x_step);
                    w_dx_nxt = w_dx_step;
                    if (w_floor) begin
                        // Missed the paddle: park on the bottom limit and stop.
                        w_y_nxt     = Y_W'(YB);
                        w_state_nxt = FROZEN;
                    end else begin
                        w_y_nxt  = Y_W'(w_y_step);
                        w_dy_nxt = w_dy_step;
                    end
                end
            end
            FROZEN: begin
                w_state_nxt = FROZEN;
            end
            default: begin
                w_state_nxt = SERVE;
            end
        endcase
    end

    assign ball_x = r_x;
    assign ball_y = r_y;
    assign moving = r_moving;

endmodule

// File: tb/tb_ball_motion.sv
// Randomized scoreboard bench for ball_motion against a signed-velocity playfield model.
module tb_ball_motion;

    localparam int M_SERVE  = 0;
    localparam int M_MOVE   = 1;
    localparam int M_FROZEN = 2;

    typedef struct {
        int x;
        int y;
        int mv;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       launch = 1'b0;
    logic [9:0] paddle_x = 10'd0;
    logic       brick_hit_x = 1'b0;
    logic       brick_hit_y = 1'b0;
    logic       gameOver = 1'b0;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       moving;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;

    int m_mode = M_SERVE;
    int m_x = 320;
    int m_y = 400;
    int m_vx = 1;
    int m_vy = -1;

    ball_motion dut (
        .clk         (clk),
        .reset       (reset),
        .launch      (launch),
        .paddle_x    (paddle_x),
        .brick_hit_x (brick_hit_x),
        .brick_hit_y (brick_hit_y),
        .gameOver    (gameOver),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .moving      (moving)
    );

    always #5 clk = ~clk;

    // Playfield rules on centre coordinates: x in 3..636, y in 3..476, paddle top row 437.
    task automatic model_step(input bit rst, input bit la, input int px,
                              input bit bx, input bit by, input bit go);
        int ox;
        int oy;
        if (rst) begin
            m_mode = M_SERVE; m_x = 320; m_y = 400; m_vx = 1; m_vy = -1;
        end else if (m_mode == M_SERVE) begin
            if (la) m_mode = M_MOVE;
        end else if (m_mode == M_MOVE) begin
            if (go) begin
                m_mode = M_FROZEN;
            end else begin
                ox = m_x;
                oy = m_y;
                if (m_vx > 0 && ox + 1 > 636)   m_vx = -1;
                else if (m_vx < 0 && ox - 1 < 3) m_vx = 1;
                else if (bx)                      m_vx = -m_vx;
                m_x = ox + m_vx;
                if (m_vy < 0 && oy - 1 < 3) begin
                    m_vy = 1;
                    m_y = oy + 1;
                end else if (m_vy > 0 && oy <= 437 && oy + 1 > 437 && ox >= px && ox <= px + 79) begin
                    m_vy = -1;
                    m_y = oy - 1;
                end else if (m_vy > 0 && oy + 1 > 476) begin
                    m_y = 476;
                    m_mode = M_FROZEN;
                end else begin
                    if (by) m_vy = -m_vy;
                    m_y = oy + m_vy;
                end
            end
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit la, input int px,
                               input bit bx, input bit by, input bit go);
        exp_t e;
        @(negedge clk);
        reset = rst;
        launch = la;
        paddle_x = 10'(px);
        brick_hit_x = bx;
        brick_hit_y = by;
        gameOver = go;
        model_step(rst, la, px, bx, by, go);
        e.x = m_x;
        e.y = m_y;
        e.mv = (m_mode == M_MOVE) ? 1 : 0;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    // Monitor: the DUT presents a position every clock; compare one queued expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (int'(ball_x) == e.x && int'(ball_y) == e.y && int'(moving) == e.mv) begin
                    n_pass++;
                end else begin
                    $display("FAIL pos_check cyc=%0d got x=%0d y=%0d moving=%0d expected x=%0d y=%0d moving=%0d",
                             e.cyc, ball_x, ball_y, moving, e.x, e.y, e.mv);
                end
            end
        end
    end

    initial begin
        int policy;
        int px;
        int frozen_hold;
        int fixed_px;
        bit bx;
        bit by;
        bit go;
        for (int ep = 0; ep < 12; ep++) begin
            policy = ep % 3;
            fixed_px = (ep == 1) ? 0 : int'($urandom_range(0, 1023));
            // Reset wins over launch, hits and gameOver.
            for (int r = 0; r < int'($urandom_range(1, 2)); r++)
                drive_cycle(1'b1, 1'($urandom), int'($urandom_range(0, 1023)),
                            1'($urandom), 1'($urandom), 1'($urandom));
            // SERVE ignores gameOver and brick pulses.
            for (int s = 0; s < int'($urandom_range(0, 4)); s++)
                drive_cycle(1'b0, 1'b0, 300, 1'($urandom), 1'($urandom), 1'($urandom));
            drive_cycle(1'b0, 1'b1, 300, 1'b0, 1'b0, 1'b0);
            frozen_hold = 0;
            for (int c = 0; c < 2000 && frozen_hold < 4; c++) begin
                if (policy == 1) begin
                    px = fixed_px;
                end else begin
                    px = m_x - int'($urandom_range(0, 79));
                    if (px < 0) px = 0;
                    if (px > 560) px = 560;
                end
                if (m_x <= 4 || m_x >= 635) bx = 1'($urandom);
                else                        bx = ($urandom_range(0, 29) == 0);
                if (m_y <= 4 || m_y == 437) by = 1'($urandom);
                else                        by = ($urandom_range(0, 29) == 0);
                go = (policy == 2) && ($urandom_range(0, 599) == 0);
                drive_cycle(1'b0, 1'($urandom), px, bx, by, go);
                if (m_mode == M_FROZEN) frozen_hold++;
            end
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got pending=%0d expected pending=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Generates the ball position for the breakout playfield (640x480).
- Owns ball velocity direction, wall/paddle/brick reflection and the serve sequence.
- Directly upstream of the ball-death detector, which consumes ball_x/ball_y; gameOver from that detector is fed back here to freeze the ball.
- Clocked by the difficulty-scaled game clock, so one position step is taken per clk while moving.

Parameters:
- X_MAX, 639, rightmost pixel column.
- Y_MAX, 479, bottom pixel row.
- BALL_R, 3, ball half-size in pixels.
- STEP, 1, pixels moved per axis per clk.
- PADDLE_Y, 440, top row of the paddle.
- PADDLE_W, 80, paddle width in pixels.
- X_START, 320, serve x position.
- Y_START, 400, serve y position.

Ports:
- clk  in  1  game clock (difficulty-scaled)
- reset  in  1  synchronous, active-high
- launch  in  1  level; starts the ball from SERVE
- paddle_x  in  10  left edge column of the paddle
- brick_hit_x  in  1  pulse; brick contact on a vertical brick face, flip x direction
- brick_hit_y  in  1  pulse; brick contact on a horizontal brick face, flip y direction
- gameOver  in  1  from the ball-death detector; freezes the ball
- ball_x  out  10  ball centre column
- ball_y  out  9  ball centre row
- moving  out  1  high while in MOVE state

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state=SERVE, ball_x=X_START, ball_y=Y_START, dx=1 (right), dy=0 (up), moving=0.
- Limits:
  - XL = BALL_R, XR = X_MAX-BALL_R.
  - YT = BALL_R, YB = Y_MAX-BALL_R.
  - PT = PADDLE_Y-BALL_R.
- States: SERVE, MOVE, FROZEN.
- SERVE:
  - ball_x=X_START and ball_y=Y_START are held; dx=1, dy=0.
  - launch=1 moves to MOVE on the next edge. The first step is taken on the edge after that.
  - gameOver is ignored in SERVE.
- MOVE, x axis (one update per clk):
  - Moving right with ball_x+STEP > XR: dx<=0, ball_x<=ball_x-STEP.
  - Moving left with ball_x < XL+STEP: dx<=1, ball_x<=ball_x+STEP.
  - Otherwise, if brick_hit_x: dx<=~dx, and ball_x steps in the new direction.
  - Otherwise: ball_x steps in dx.
- MOVE, y axis:
  - Moving up with ball_y < YT+STEP: dy<=1, ball_y<=ball_y+STEP.
  - Paddle hit: moving down, ball_y <= PT, ball_y+STEP > PT, and paddle_x <= ball_x <= paddle_x+PADDLE_W-1 (11-bit compare, no wrap). Then dy<=0, ball_y<=ball_y-STEP.
  - Moving down with ball_y+STEP > YB: ball_y<=YB, dy unchanged, state<=FROZEN.
  - Otherwise, if brick_hit_y: dy<=~dy, and ball_y steps in the new direction.
  - Otherwise: ball_y steps in dy.
- Priority: wall/paddle reflection beats the brick flip on the same axis; that brick pulse is dropped. The axes are independent, so a corner reflects both.
- Missed paddle: ball continues downward through rows 453..457 (the death band) and stops at YB.
- gameOver=1 in MOVE: FROZEN on the next edge. The position update for that edge is suppressed; the position holds the value present when gameOver was sampled.
- FROZEN: ball_x/ball_y hold; moving=0; leaves only via reset.
- Reset mid-MOVE: next edge returns to the SERVE values, regardless of launch or hit inputs.
- Arithmetic: position math done in 11 bits and then truncated. Limits guarantee no under- or overflow.

Decomposition:
- Package breakout_pkg holds:
  - ball_state_t enum {SERVE, MOVE, FROZEN}
  - screen constants X_MAX, Y_MAX
  - PADDLE_Y, PADDLE_W, BALL_R
- Sub-module axis_step: one axis.
  - Inputs: pos, dir, lo, hi, flip_req, force_reflect.
  - Outputs: next_pos, next_dir, at_limit.
  - Instantiated once per axis; paddle-hit logic sits in the top and drives force_reflect on y.

Test Plan:
- Reset, then launch=1 for 1 clk -> ball (320,400); first step gives (321,399), then (322,398); moving=1.
- Right wall: force ball_x=636 with dx=1 -> ball_x 636->635, dx=0.
- Paddle catch: paddle_x=300, ball at (330,437) moving down -> ball_y 436, dy=0.
- Same approach with paddle_x=0 -> ball passes 437..476 and holds at ball_y=476; state FROZEN, moving=0.
- Simultaneous:
  - brick_hit_y=1 on the same clk as a top-wall reflect at ball_y=3 -> ball_y=4, dy=1 (brick ignored).
  - brick_hit_x alone mid-field at x=200, dx=1 -> x=199, dx=0.
- gameOver=1 at (250,455) -> position frozen at (250,455) on all later clks; reset -> (320,400) in SERVE.
